// File: rtl/prienc_pkg.sv
// Shared widths and core-style selector for the 8-to-3 priority encoder.
package prienc_pkg;

    localparam int unsigned PRIENC_IN_W  = 8;
    localparam int unsigned PRIENC_OUT_W = 3;

    // Implementation style of one combinational encoder core.
    typedef enum logic [1:0] {
        PRIENC_IF    = 2'd0,
        PRIENC_FOR   = 2'd1,
        PRIENC_CASEZ = 2'd2
    } prienc_style_e;

endpackage : prienc_pkg

// File: rtl/prienc_core.sv
// Combinational 8-to-3 priority encoder core; bit 7 has highest priority.
// Ports:
//   a     - request vector
//   y     - index of the most significant set bit of a (0 when a == 0)
//   valid - 1 when any bit of a is set
// STYLE selects an if/else-if chain, a descending for-loop or a casez.
module prienc_core
    import prienc_pkg::*;
#(
    parameter prienc_style_e STYLE = PRIENC_IF
) (
    input  logic [PRIENC_IN_W-1:0]  a,
    output logic [PRIENC_OUT_W-1:0] y,
    output logic                    valid
);

    if (STYLE == PRIENC_FOR) begin : g_for
        // Descending scan; the first hit wins and later hits are ignored.
        always_comb begin
            logic found;
            y     = '0;
            found = 1'b0;
            for (int i = int'(PRIENC_IN_W) - 1; i >= 0; i--) begin
                if (a[i] && !found) begin
                    y     = PRIENC_OUT_W'(i);
                    found = 1'b1;
                end
            end
            valid = found;
        end
    end else if (STYLE == PRIENC_CASEZ) begin : g_casez
        always_comb begin
            y     = '0;
            valid = 1'b1;
            casez (a)
                8'b1???????: y = 3'd7;
                8'b01??????: y = 3'd6;
                8'b001?????: y = 3'd5;
                8'b0001????: y = 3'd4;
                8'b00001???: y = 3'd3;
                8'b000001??: y = 3'd2;
                8'b0000001?: y = 3'd1;
                8'b00000001: y = 3'd0;
                default: begin
                    y     = 3'd0;
                    valid = 1'b0;
                end
            endcase
        end
    end else begin : g_if
        always_comb begin
            y     = '0;
            valid = |a;
            if      (a[7]) y = 3'd7;
            else if (a[6]) y = 3'd6;
            else if (a[5]) y = 3'd5;
            else if (a[4]) y = 3'd4;
            else if (a[3]) y = 3'd3;
            else if (a[2]) y = 3'd2;
            else if (a[1]) y = 3'd1;
            else           y = 3'd0;
        end
    end

endmodule : prienc_core

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   A        - request vector, bit 7 highest priority
//   Y        - registered index of highest set bit of A
//   Valid    - registered, 1 when A was nonzero
//   mismatch - sticky cross-check error flag (0 unless PRIENC_XCHECK_EN)
// Macro PRIENC_XCHECK_EN: build three independent cores and flag any
// disagreement between them; the if-chain core always drives Y/Valid.
module priority_encoder_8to3
    import prienc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRIENC_IN_W-1:0]  A,
    output logic [PRIENC_OUT_W-1:0] Y,
    output logic                    Valid,
    output logic                    mismatch
);

    logic [PRIENC_OUT_W-1:0] y_d, y_q;
    logic                    valid_d, valid_q;

    prienc_core #(.STYLE(PRIENC_IF)) u_core_if (
        .a     (A),
        .y     (y_d),
        .valid (valid_d)
    );

    // Output registers; reset overrides capture of A.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y     = y_q;
    assign Valid = valid_q;

`ifdef PRIENC_XCHECK_EN
    logic [PRIENC_OUT_W-1:0] y_for, y_casez;
    logic                    valid_for, valid_casez;
    logic                    mismatch_d, mismatch_q;

    prienc_core #(.STYLE(PRIENC_FOR)) u_core_for (
        .a     (A),
        .y     (y_for),
        .valid (valid_for)
    );

    prienc_core #(.STYLE(PRIENC_CASEZ)) u_core_casez (
        .a     (A),
        .y     (y_casez),
        .valid (valid_casez)
    );

    // Sticky: any disagreement among the three cores latches until reset.
    always_comb begin
        mismatch_d = mismatch_q;
        if ({y_d, valid_d} != {y_for, valid_for} ||
            {y_d, valid_d} != {y_casez, valid_casez}) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mismatch_q <= 1'b0;
        else     mismatch_q <= mismatch_d;
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule : priority_encoder_8to3

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: reference model plus
// directed vectors with hand-computed expectations.
module tb_priority_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A   = 8'h00;
    logic [2:0] Y;
    logic       Valid;
    logic       mismatch;

    int checks = 0;
    int fails  = 0;

    // Reference state: what outputs must be after the most recent edge.
    logic [2:0] exp_y     = 3'd0;
    logic       exp_v     = 1'b0;
    logic       exp_mm    = 1'b0;
    logic       exp_known = 1'b0;
    logic       force_on  = 1'b0;

    priority_encoder_8to3 dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .Y        (Y),
        .Valid    (Valid),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Index of highest set bit by repeated halving (floor(log2(a))).
    function automatic logic [2:0] msb_index(input logic [7:0] a);
        int v;
        int n;
        v = int'(a);
        n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return 3'(n);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_y  = 3'd0;
            exp_v  = 1'b0;
            exp_mm = 1'b0;
        end else begin
            exp_y  = (A == 8'd0) ? 3'd0 : msb_index(A);
            exp_v  = (A != 8'd0);
            exp_mm = exp_mm | force_on;
        end
        exp_known = 1'b1;
    end

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (exp_known) begin
            checks++;
            if (Y !== exp_y || Valid !== exp_v || mismatch !== exp_mm) begin
                fails++;
                $display("FAIL model t=%0t A=%02h got Y=%0d V=%b mm=%b want Y=%0d V=%b mm=%b",
                         $time, A, Y, Valid, mismatch, exp_y, exp_v, exp_mm);
            end
        end
    end

    task automatic cyc(input logic [7:0] a, input logic r);
        @(negedge clk);
        A   = a;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [2:0] y, input logic v, input logic mm);
        checks++;
        if (Y !== y || Valid !== v || mismatch !== mm) begin
            fails++;
            $display("FAIL %s got Y=%0d V=%b mm=%b want Y=%0d V=%b mm=%b",
                     name, Y, Valid, mismatch, y, v, mm);
        end
    endtask

    initial begin
        // Reset with all requests asserted.
        cyc(8'hFF, 1'b1);
        lit("reset_1", 3'd0, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1);
        lit("reset_2", 3'd0, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0);
        lit("release_ff", 3'd7, 1'b1, 1'b0);

        // Exhaustive sweep with literal spot checks.
        for (int i = 0; i < 256; i++) begin
            cyc(8'(i), 1'b0);
            case (i)
                0:   lit("sweep_0",   3'd0, 1'b0, 1'b0);
                1:   lit("sweep_1",   3'd0, 1'b1, 1'b0);
                5:   lit("sweep_5",   3'd2, 1'b1, 1'b0);
                7:   lit("sweep_7",   3'd2, 1'b1, 1'b0);
                64:  lit("sweep_64",  3'd6, 1'b1, 1'b0);
                127: lit("sweep_127", 3'd6, 1'b1, 1'b0);
                200: lit("sweep_200", 3'd7, 1'b1, 1'b0);
                default: ;
            endcase
        end

        // Priority masking.
        cyc(8'b0001_1111, 1'b0);
        lit("mask_1f", 3'd4, 1'b1, 1'b0);
        cyc(8'b0100_0001, 1'b0);
        lit("mask_41", 3'd6, 1'b1, 1'b0);
        cyc(8'b1010_0101, 1'b0);
        lit("mask_a5", 3'd7, 1'b1, 1'b0);

        // Back-to-back.
        cyc(8'h80, 1'b0);
        lit("b2b_80", 3'd7, 1'b1, 1'b0);
        cyc(8'h01, 1'b0);
        lit("b2b_01", 3'd0, 1'b1, 1'b0);
        cyc(8'h00, 1'b0);
        lit("b2b_00", 3'd0, 1'b0, 1'b0);

        // Mid-stream reset.
        cyc(8'h08, 1'b0);
        lit("pre_rst_08", 3'd3, 1'b1, 1'b0);
        cyc(8'h10, 1'b1);
        lit("mid_rst", 3'd0, 1'b0, 1'b0);
        cyc(8'h10, 1'b0);
        lit("post_rst_10", 3'd4, 1'b1, 1'b0);

`ifdef PRIENC_XCHECK_EN
        // Corrupt the for-loop core while A=0 so it disagrees with the if-chain.
        @(negedge clk);
        A        = 8'h00;
        force_on = 1'b1;
        force dut.u_core_for.y = 3'd5;
        @(posedge clk);
        #1;
        lit("xchk_set", 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        release dut.u_core_for.y;
        force_on = 1'b0;
        cyc(8'h22, 1'b0);
        lit("xchk_hold", 3'd5, 1'b1, 1'b1);
        cyc(8'h22, 1'b1);
        lit("xchk_clear", 3'd0, 1'b0, 1'b0);
        cyc(8'h22, 1'b0);
        lit("xchk_after", 3'd5, 1'b1, 1'b0);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_priority_encoder_8to3

// File: doc/priority_encoder_8to3.md
# priority_encoder_8to3

Registered 8-to-3 priority encoder: reports the index of the highest-set bit of an 8-bit request vector plus a valid flag. Used wherever a one-of-eight request must be reduced to a binary index, such as interrupt or arbitration front-ends. The core is combinational. Outputs are registered on one clock with a synchronous, active-high reset.

## Interface
- Parameters: none. Widths are fixed constants from the shared package.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- A  input  8  request vector; bit 7 has highest priority.
- Y  output  3  registered index of the highest set bit of A.
- Valid  output  1  registered; 1 when any bit of A was set.
- mismatch  output  1  sticky cross-check error flag. Tied to 0 unless the `_EN` macro below is defined.

## Operation
- Combinational core: Y_next = index of the most significant 1 in A.
  - Ranges: A≥128→7, 64–127→6, 32–63→5, 16–31→4, 8–15→3, 4–7→2, 2–3→1, 1→0.
- Valid_next = |A. This is 1 for every nonzero A, including the range 4–7.
- A = 0: Valid_next = 0 and Y_next = 3'd0. Y is never X or Z.
- Lower-priority bits are ignored once a higher bit is set. Example: A=8'b1010_0101 → Y=7.
- Core is pure combinational. No latches; a default assignment is required on every path.

## Timing
- A is sampled at each rising clk edge. Y/Valid reflect it after that edge: latency 1 cycle, throughput 1 per cycle.
- rst=1 at an edge: Y=0, Valid=0, mismatch=0. Reset overrides capture of A.
- Reset asserted mid-stream: outputs clear on the next edge. On the first edge after rst deasserts, the current A is captured.
- No handshake. A must be stable around the clk edge; it is not synchronized internally.

## Configuration
- PRIENC_XCHECK_EN defined:
  - Instantiate three independent core implementations: if/else-if chain, descending for-loop, casez with wildcards.
  - The if-chain result drives Y/Valid.
  - Each cycle, compare all three {Y_next, Valid_next}. Any disagreement sets mismatch on the next edge. It stays 1 until rst.
- PRIENC_XCHECK_EN undefined: only the if-chain core is built; mismatch is constant 0.
- Functional Y/Valid timing is identical in both builds.

## Structure
- Package prienc_pkg:
  - PRIENC_IN_W=8, PRIENC_OUT_W=3.
  - Enum/typedef for the selected core style: PRIENC_IF, PRIENC_FOR, PRIENC_CASEZ.
- Sub-module prienc_core: combinational, with a style parameter selecting the if/for/casez implementation.
  - Top instantiates one prienc_core, or three under the macro.
  - Top holds the output registers and the mismatch register.

## Test plan
- Reset: hold rst=1 with A=8'hFF for 2 cycles → Y=0, Valid=0, mismatch=0. Release; next edge → Y=7, Valid=1.
- Exhaustive sweep A=0..255, one value per cycle. Each result one cycle later must match the reference ranges: A=0→Valid=0,Y=0; A=5→Y=2,Valid=1; A=200→Y=7; A=1→Y=0.
- Priority masking: A=8'b0001_1111 → Y=4; A=8'b0100_0001 → Y=6.
- Back-to-back: A=8'h80, 8'h01, 8'h00 on consecutive cycles → Y=7,0,0 and Valid=1,1,0 on successive edges.
- Mid-stream reset: rst=1 for one cycle while A=8'h10 → outputs 0 that cycle, Y=4 the cycle after.
- With PRIENC_XCHECK_EN: run the full sweep → mismatch stays 0. Force one core's output via a bench override → mismatch=1 next edge, holds until rst.
